sub_div: RTL and testbench

- Sequential signed fixed-point unit computing Q = (D - C) / B, the inverse of the existing A*B+C ALU.
- Given a product-plus-offset result and one factor, it recovers the other factor.
- Used in the EKF datapath for the Kalman gain divide (numerator minus offset, divided by innovation covariance).
- Restoring division, one quotient bit per cycle, valid/ready on both sides.

---
 rtl/ekf_fxp_pkg.sv | 31 +++
 rtl/div_core.sv | 61 ++++++
 rtl/sub_div.sv | 144 ++++++++++++++
 tb/tb_sub_div.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ekf_fxp_pkg.sv
// Shared fixed-point helpers for the EKF datapath: format derivation,
// divider sizing, FSM encodings and saturation limits.
package ekf_fxp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_DIV  = 3'd2,
    ST_SIGN = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int flt_bits(input int dw, input int int_bits);
    return dw - int_bits - 1;
  endfunction

  // Pre-shift of |D-C| so the quotient lands directly in the Q format.
  function automatic int shift_bits(input int flt_q, input int flt_b, input int flt_d);
    return flt_q + flt_b - flt_d;
  endfunction

  function automatic int nw_bits(input int dw_d, input int shift);
    return dw_d + shift;
  endfunction

  // Largest positive magnitude of a dw-bit signed value; valid for dw <= 64.
  function automatic logic [63:0] sat_max(input int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// done is high during the final iteration so the caller can leave on that edge.
module div_core #(
  parameter int NW   = 44,
  parameter int DW_B = 24
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            load,
  input  logic [NW-1:0]   num,
  input  logic [DW_B-1:0] den,
  output logic            busy,
  output logic [NW-1:0]   quo,
  output logic            done
);

  localparam int CW = $clog2(NW + 1);

  logic [DW_B:0]   rem_r;
  logic [NW-1:0]   q_r;
  logic [DW_B-1:0] den_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic [DW_B:0]   rem_sh;
  logic [DW_B:0]   trial;
  logic            ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh = {rem_r[DW_B-1:0], q_r[NW-1]};
    trial  = rem_sh - {1'b0, den_r};
    ge     = (rem_sh >= {1'b0, den_r});
  end

  // Iteration state: remainder, quotient/dividend shift register and bit counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem_r  <= {(DW_B+1){1'b0}};
      q_r    <= {NW{1'b0}};
      den_r  <= {DW_B{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (load) begin
      rem_r  <= {(DW_B+1){1'b0}};
      q_r    <= num;
      den_r  <= den;
      cnt_r  <= CW'(NW);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= ge ? trial : rem_sh;
      q_r    <= {q_r[NW-2:0], ge};
      cnt_r  <= cnt_r - CW'(1);
      busy_r <= (cnt_r != CW'(1));
    end
  end

  assign busy = busy_r;
  assign quo  = q_r;
  assign done = busy_r && (cnt_r == CW'(1));

endmodule

// File: rtl/sub_div.sv
// Signed fixed-point Q = (D - C) / B: subtract/sign front end, restoring
// divider, symmetric saturation back end, valid/ready on both sides.
module sub_div
  import ekf_fxp_pkg::*;
#(
  parameter int DW_D  = 24,
  parameter int INT_D = 3,
  parameter int DW_B  = 24,
  parameter int INT_B = 3,
  parameter int DW_Q  = 24,
  parameter int INT_Q = 3
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_D-1:0] din_d,
  input  logic [DW_D-1:0] din_c,
  input  logic [DW_B-1:0] din_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_Q-1:0] dout,
  output logic            ovf,
  output logic            dz
);

  localparam int FLT_D = flt_bits(DW_D, INT_D);
  localparam int FLT_B = flt_bits(DW_B, INT_B);
  localparam int FLT_Q = flt_bits(DW_Q, INT_Q);
  localparam int SHIFT = shift_bits(FLT_Q, FLT_B, FLT_D);
  localparam int NW    = nw_bits(DW_D, SHIFT);
  localparam logic [DW_Q-1:0] Q_MAX = DW_Q'(sat_max(DW_Q));

  if (FLT_Q + FLT_B < FLT_D) begin : g_illegal_format
    $error("sub_div: FLT_Q + FLT_B must be >= FLT_D");
  end

  state_e          state, next_state;
  logic [DW_D-1:0] d_r, c_r;
  logic [DW_B-1:0] b_r;
  logic            neg_r, dz_r;
  logic            accept;
  logic [DW_D:0]   diff, diff_mag;
  logic [DW_B-1:0] b_mag;
  logic            b_zero;
  logic [NW-1:0]   num;
  logic            load;
  logic            core_busy, core_done;
  logic [NW-1:0]   quo;
  logic            q_hi, sat;
  logic [DW_Q-1:0] mag, res;

  assign accept = in_valid && in_ready;

  // Front end: widened difference, magnitudes and aligned dividend.
  always_comb begin
    diff     = {d_r[DW_D-1], d_r} - {c_r[DW_D-1], c_r};
    diff_mag = diff[DW_D] ? ((DW_D+1)'(0) - diff) : diff;
    b_mag    = b_r[DW_B-1] ? (DW_B'(0) - b_r) : b_r;
    b_zero   = (b_r == {DW_B{1'b0}});
    num      = NW'(diff_mag) << SHIFT;
    load     = (state == ST_PREP) && !b_zero;
  end

  div_core #(.NW(NW), .DW_B(DW_B)) u_core (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (load),
    .num   (num),
    .den   (b_mag),
    .busy  (core_busy),
    .quo   (quo),
    .done  (core_done)
  );

  // Back end: any set bit at or above the sign position saturates; zero stays +0.
  always_comb begin
    q_hi = |quo[NW-1:DW_Q-1];
    sat  = dz_r || q_hi;
    mag  = sat ? Q_MAX : {1'b0, quo[DW_Q-2:0]};
    res  = (neg_r && (mag != {DW_Q{1'b0}})) ? (DW_Q'(0) - mag) : mag;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = accept ? ST_PREP : ST_IDLE;
      ST_PREP: next_state = b_zero ? ST_SIGN : ST_DIV;
      ST_DIV:  next_state = core_done ? ST_SIGN : ST_DIV;
      ST_SIGN: next_state = ST_DONE;
      ST_DONE: next_state = out_ready ? ST_IDLE : ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture on accept; sign and divide-by-zero decided in PREP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_r   <= {DW_D{1'b0}};
      c_r   <= {DW_D{1'b0}};
      b_r   <= {DW_B{1'b0}};
      neg_r <= 1'b0;
      dz_r  <= 1'b0;
    end else if (accept) begin
      d_r <= din_d;
      c_r <= din_c;
      b_r <= din_b;
    end else if (state == ST_PREP) begin
      // With B == 0 the sign bit of B is 0, so this reduces to sign(diff).
      neg_r <= diff[DW_D] ^ b_r[DW_B-1];
      dz_r  <= b_zero;
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dout      <= {DW_Q{1'b0}};
      ovf       <= 1'b0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= (next_state == ST_DONE);
      in_ready  <= (next_state == ST_IDLE);
      if (accept) begin
        ovf <= 1'b0;
        dz  <= 1'b0;
      end else if (state == ST_SIGN) begin
        dout <= res;
        ovf  <= sat;
        dz   <= dz_r;
      end
    end
  end

endmodule

// File: tb/tb_sub_div.sv
// Directed self-checking bench for sub_div (Q3.20 operands and result).
module tb_sub_div;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] din_d = 24'h0, din_c = 24'h0, din_b = 24'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] dout;
  logic        ovf, dz;

  int n_cmp = 0;
  int n_bad = 0;

  sub_div dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .din_d(din_d), .din_c(din_c), .din_b(din_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d, c, b, q;
    logic        ovf, dz;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: handshake in, measure latency, check result, drain.
  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    din_d = v.d; din_c = v.c; din_b = v.b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_flags_clear"}, {62'd0, ovf, dz}, 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, "_dout"}, 64'(dout), 64'(v.q));
    chk({tag, "_ovf"}, 64'(ovf), 64'(v.ovf));
    chk({tag, "_dz"}, 64'(dz), 64'(v.dz));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    logic seen;
    //          d            c            b            q          ovf   dz    lat
    vecs[0]  = '{24'h200000, 24'h080000, 24'h180000, 24'h100000, 1'b0, 1'b0, 46};
    vecs[1]  = '{24'hF00000, 24'h080000, 24'h0C0000, 24'hE00000, 1'b0, 1'b0, 46};
    vecs[2]  = '{24'hF00000, 24'h080000, 24'hF40000, 24'h200000, 1'b0, 1'b0, 46};
    vecs[3]  = '{24'h100000, 24'h000000, 24'h300000, 24'h055555, 1'b0, 1'b0, 46};
    vecs[4]  = '{24'hF00000, 24'h000000, 24'h300000, 24'hFAAAAB, 1'b0, 1'b0, 46};
    vecs[5]  = '{24'h700000, 24'hF1999A, 24'h080000, 24'h7FFFFF, 1'b1, 1'b0, 46};
    vecs[6]  = '{24'h100000, 24'h000000, 24'h000000, 24'h7FFFFF, 1'b1, 1'b1, 2};
    vecs[7]  = '{24'hF00000, 24'h000000, 24'h000000, 24'h800001, 1'b1, 1'b1, 2};
    vecs[8]  = '{24'h123456, 24'h123456, 24'h100000, 24'h000000, 1'b0, 1'b0, 46};
    vecs[9]  = '{24'h000000, 24'h000001, 24'h7FFFFF, 24'h000000, 1'b0, 1'b0, 46};
    vecs[10] = '{24'h800000, 24'h000000, 24'h080000, 24'h800001, 1'b1, 1'b0, 46};
    vecs[11] = '{24'h7FFFFF, 24'h000000, 24'h100000, 24'h7FFFFF, 1'b0, 1'b0, 46};
    vecs[12] = '{24'h800000, 24'h000000, 24'h100000, 24'h800001, 1'b1, 1'b0, 46};
    vecs[13] = '{24'h100000, 24'h000000, 24'h800000, 24'hFE0000, 1'b0, 1'b0, 46};
    vecs[14] = '{24'h000003, 24'h000000, 24'h200000, 24'h000001, 1'b0, 1'b0, 46};
    vecs[15] = '{24'hFFFFFD, 24'h000000, 24'h200000, 24'hFFFFFF, 1'b0, 1'b0, 46};

    repeat (3) tick();
    chk("reset_outputs", {35'd0, in_ready, out_valid, ovf, dz, dout}, {35'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_op(vecs[i], i);

    // Output hold with out_ready low, then release and a back-to-back op.
    din_d = vecs[5].d; din_c = vecs[5].c; din_b = vecs[5].b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("hold_latency", 64'(cyc), 64'd46);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_c%0d", i), {36'd0, out_valid, in_ready, ovf, dz, dout},
          {36'd0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h7FFFFF});
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release", {62'd0, out_valid, in_ready}, 64'd1);
    run_op(vecs[3], 100);

    // Reset during DIV: outputs clear immediately and the op never completes.
    din_d = vecs[0].d; din_c = vecs[0].c; din_b = vecs[0].b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (21) tick();
    n_rst = 1'b0;
    #1;
    chk("abort_outputs", {35'd0, in_ready, out_valid, ovf, dz, dout}, {35'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    repeat (2) tick();
    n_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_op(vecs[1], 200);
    run_op(vecs[6], 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
